// File: rtl/and4_chk_pkg.sv
// Shared types and sizes for the 4-input AND gate sweep checker.
package and4_chk_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/and4_sweep_checker.sv
// Drives all 16 input vectors into an external AND4 gate, samples f after a
// settle time and reports mismatch count, first failing vector and pass/fail.
module and4_sweep_checker
  import and4_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("and4_sweep_checker: SETTLE_CYCLES must be >= 1");
  end

  // Counter must reach SETTLE_CYCLES, since it increments on the exit cycle too.
  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_t             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [ERR_W-1:0]   r_err_count;
  logic               r_fail_valid;
  logic [VEC_W-1:0]   r_first_fail_vec;
  logic               r_pass;

  logic               w_expected;
  logic               w_mismatch;
  logic [ERR_W-1:0]   w_err_next;

  assign w_expected = &r_vec;
  assign w_mismatch = (f != w_expected);
  assign w_err_next = r_err_count + {{(ERR_W-1){1'b0}}, w_mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_vec            <= '0;
      r_settle_cnt     <= '0;
      r_err_count      <= '0;
      r_fail_valid     <= 1'b0;
      r_first_fail_vec <= '0;
      r_pass           <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec            <= '0;
            r_settle_cnt     <= '0;
            r_err_count      <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= '0;
            r_pass           <= 1'b0;
            r_state          <= SETTLE;
          end
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_first_fail_vec <= r_vec;
            r_fail_valid     <= 1'b1;
          end
          if (r_vec == VEC_LAST) begin
            // Resolve pass one cycle early so it is already valid while done is high.
            r_pass  <= (w_err_next == '0);
            r_state <= DONE;
          end else begin
            r_vec        <= r_vec + 1'b1;
            r_settle_cnt <= '0;
            r_state      <= SETTLE;
          end
        end
        DONE: begin
          r_pass  <= (r_err_count == '0);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a              = r_vec[3];
  assign b              = r_vec[2];
  assign c              = r_vec[1];
  assign d              = r_vec[0];
  assign busy           = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done           = (r_state == DONE);
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign fail_valid     = r_fail_valid;
  assign first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_and4_sweep_checker.sv
// Directed bench: sweeps the checker against a good gate and several faulty gates.
module tb_and4_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] fmode = 2'd0;
  logic       sel = 1'b0;

  logic       a0, b0, c0, d0, f0, busy0, done0, pass0, fv0;
  logic [4:0] err0;
  logic [3:0] ffv0;
  logic       a1, b1, c1, d1, f1, busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] ffv1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // fmode: 0 good gate, 1 stuck-at-0, 2 stuck-at-1, 3 ~a&b&c&d
  always_comb begin
    f0 = a0 & b0 & c0 & d0;
    case (fmode)
      2'd1:    f0 = 1'b0;
      2'd2:    f0 = 1'b1;
      2'd3:    f0 = ~a0 & b0 & c0 & d0;
      default: f0 = a0 & b0 & c0 & d0;
    endcase
  end
  assign f1 = a1 & b1 & c1 & d1;

  and4_sweep_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0), .f(f0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_vec(ffv0)
  );

  and4_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  logic       v_busy, v_done, v_pass, v_fv;
  logic [4:0] v_err;
  logic [3:0] v_ffv, v_abcd;
  assign v_busy = sel ? busy1 : busy0;
  assign v_done = sel ? done1 : done0;
  assign v_pass = sel ? pass1 : pass0;
  assign v_fv   = sel ? fv1 : fv0;
  assign v_err  = sel ? err1 : err0;
  assign v_ffv  = sel ? ffv1 : ffv0;
  assign v_abcd = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};

  int         done_cyc, done_cnt;
  logic       busy_c1, s_pass, s_fv;
  logic [4:0] s_err;
  logic [3:0] s_ffv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, 32'(v_busy), 0);
    check({tag, ".done"}, 32'(v_done), 0);
    check({tag, ".pass"}, 32'(v_pass), 0);
    check({tag, ".err"},  32'(v_err),  0);
    check({tag, ".fv"},   32'(v_fv),   0);
    check({tag, ".ffv"},  32'(v_ffv),  0);
    check({tag, ".abcd"}, 32'(v_abcd), 0);
  endtask

  // Pulses start, then watches 70 cycles; cycle 1 is the one right after the start edge.
  task automatic sweep(input int repulse_vec, input int rst_vec);
    bit repulsed = 0;
    done_cyc = 0; done_cnt = 0; busy_c1 = 0;
    s_pass = 0; s_fv = 0; s_err = '0; s_ffv = '0;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc == 1) busy_c1 = v_busy;
      if (v_done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          s_pass = v_pass; s_err = v_err; s_fv = v_fv; s_ffv = v_ffv;
        end
      end
      if (rst_vec >= 0 && cyc > 1 && 32'(v_abcd) == rst_vec) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("abort");
        rst = 1'b0;
        $display("sweep aborted by reset at vector %0d", rst_vec);
        return;
      end
      if (!repulsed && repulse_vec >= 0 && 32'(v_abcd) == repulse_vec) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        repulsed = 1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    $display("sweep sel=%0d fmode=%0d: done_cyc=%0d done_cnt=%0d pass=%0d err=%0d fv=%0d ffv=%h",
             sel, fmode, done_cyc, done_cnt, s_pass, s_err, s_fv, s_ffv);
  endtask

  task automatic check_sweep(input string tag, input int exp_cyc, input int exp_pass,
                             input int exp_err, input int exp_fv, input int exp_ffv);
    check({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, ".done_cnt"}, 32'(done_cnt), 1);
    check({tag, ".busy_c1"},  32'(busy_c1),  1);
    check({tag, ".pass"},     32'(s_pass),   32'(exp_pass));
    check({tag, ".err"},      32'(s_err),    32'(exp_err));
    check({tag, ".fv"},       32'(s_fv),     32'(exp_fv));
    if (exp_fv != 0) check({tag, ".ffv"}, 32'(s_ffv), 32'(exp_ffv));
    check({tag, ".abcd_after"}, 32'(v_abcd), 32'hF);
    check({tag, ".busy_after"}, 32'(v_busy), 0);
    check({tag, ".pass_held"},  32'(v_pass), 32'(exp_pass));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    fmode = 2'd0; sweep(-1, -1);
    check_sweep("good", 49, 1, 0, 0, 0);

    fmode = 2'd1; sweep(-1, -1);
    check_sweep("stuck0", 49, 0, 1, 1, 4'hF);

    fmode = 2'd2; sweep(-1, -1);
    check_sweep("stuck1", 49, 0, 15, 1, 4'h0);

    fmode = 2'd3; sweep(-1, -1);
    check_sweep("nota", 49, 0, 2, 1, 4'h7);

    fmode = 2'd0; sweep(5, -1);
    check_sweep("repulse", 49, 1, 0, 0, 0);

    fmode = 2'd2; sweep(-1, 7);
    @(negedge clk);

    fmode = 2'd0; sweep(-1, -1);
    check_sweep("after_rst", 49, 1, 0, 0, 0);

    sel = 1'b1; sweep(-1, -1);
    check_sweep("settle1", 33, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and4_sweep_checker.md
Name: and4_sweep_checker

Overview:
- Self-contained stimulus and check stage wrapped around the 4-input AND gate.
- Drives a, b, c, d through all 16 input combinations in ascending order, a-major (a is the MSB, d is the LSB).
- After a programmable settle time, samples the gate output f and compares it against the expected value a&b&c&d.
- Counts mismatches, captures the first failing vector, and reports pass/fail with a start/done handshake.
- Sits directly upstream of the gate (feeds its inputs) and directly downstream of it (consumes f) in the board-level self-test top.

Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before f is sampled. Must be >= 1; 0 is illegal and is flagged by an elaboration assertion.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep; honoured only in IDLE.
- a  output  1  gate input, vec[3], registered.
- b  output  1  gate input, vec[2], registered.
- c  output  1  gate input, vec[1], registered.
- d  output  1  gate input, vec[0], registered.
- f  input  1  gate output; combinational from a..d, sampled without a synchronizer.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse marking the end of a sweep.
- pass  output  1  1 when the last sweep had err_count==0; held until the next start.
- err_count  output  5  mismatches in the last sweep, range 0..16; no saturation needed.
- fail_valid  output  1  set when at least one mismatch was seen in the current or last sweep.
- first_fail_vec  output  4  {a,b,c,d} of the first mismatch; valid only while fail_valid=1.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - vec=0, hence a=b=c=d=0.
  - settle_cnt=0.
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0.
- Reset mid-sweep aborts immediately, with the same values as above.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> vec<=0, settle_cnt<=0, err_count<=0, fail_valid<=0, first_fail_vec<=0, pass<=0, state<=SETTLE.
  - Otherwise hold; result outputs keep the values from the last sweep.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 -> state<=SAMPLE.
  - vec is held stable.
- SAMPLE: expected = &vec.
  - If f!=expected: err_count<=err_count+1.
  - If additionally fail_valid==0: first_fail_vec<=vec and fail_valid<=1.
  - If vec==4'hF -> state<=DONE.
  - Else vec<=vec+1, settle_cnt<=0, state<=SETTLE.
  - The compare in the SAMPLE cycle uses the pre-increment vec.
- DONE:
  - done=1 for exactly this one cycle.
  - pass<=(err_count==0), using the final count including the last sample.
  - state<=IDLE.
  - vec stays at 4'hF until the next start, so a..d remain 1111 after the sweep.
- busy = (state==SETTLE || state==SAMPLE).
- start is ignored while in SETTLE, SAMPLE or DONE; no queuing.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in the cycle 16*(SETTLE_CYCLES+1)+1 cycles after the edge at which start was sampled. This is 49 for the default.
  - pass is valid from that same cycle onward.
- Back-to-back sweeps: start asserted in the first IDLE cycle after DONE is accepted.
- No combinational path from f to any output.

Decomposition:
- Shared package and4_chk_pkg holds:
  - the state enum typedef (IDLE, SETTLE, SAMPLE, DONE), 2-bit encoding;
  - localparam VEC_W=4;
  - localparam NUM_VEC=16;
  - localparam ERR_W=5.
- No sub-module. The gate under test is instantiated next to this block by the self-test top, not inside it.

Test Plan:
- Real and4gate wired to a..d/f, start pulsed once -> done pulse 49 cycles later; pass=1, err_count=0, fail_valid=0, a..d=1111 afterwards.
- f tied to 0 (stuck-at-0), start -> err_count=1, fail_valid=1, first_fail_vec=4'hF, pass=0.
- f tied to 1 (stuck-at-1), start -> err_count=15, first_fail_vec=4'h0, pass=0.
- Faulty gate with f=~a&b&c&d, start -> err_count=2, first_fail_vec=4'h7, pass=0.
- Re-pulse start mid-sweep at vector 5 -> ignored; done still at cycle 49, single done pulse. Then assert rst at vector 7 -> next cycle all outputs 0 and busy=0; a following start completes a normal sweep with pass=1.
- SETTLE_CYCLES=1 with the real gate -> done at cycle 33 after start; SETTLE_CYCLES=0 -> elaboration error.
